// File: rtl/pc_unit_if.sv
// Command/status bundle between the fetch sequencer and the program-counter stage.
// The master issues commands; the slave (pc_unit) returns pc and stack status.
interface pc_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             en;
  logic             inc;
  logic             jmp;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] addr;
  logic             clr_err;
  logic [WIDTH-1:0] pc;
  logic [SPW-1:0]   sp_level;
  logic             stk_full;
  logic             stk_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output en, inc, jmp, call, ret, addr, clr_err,
    input  pc, sp_level, stk_full, stk_empty, overflow, underflow
  );

  modport slave (
    input  en, inc, jmp, call, ret, addr, clr_err,
    output pc, sp_level, stk_full, stk_empty, overflow, underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with increment/jump/call/return and a small return-address stack.
// Command priority is call > ret > jmp > inc; error flags are sticky until clr_err.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
  input logic       clk,
  input logic       rst_n,
  pc_unit_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] top_s;
  logic             full_s;
  logic             empty_s;

  assign pc_inc_s = pc_q + WIDTH'(1);
  assign full_s   = (sp_q == SPW'(DEPTH));
  assign empty_s  = (sp_q == SPW'(0));

  // Entry currently on top of the stack (only meaningful when not empty).
  always_comb begin
    top_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (SPW'(i) == sp_q - SPW'(1)) begin
        top_s = stack_q[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Next-state: clear is honoured even when en=0, and a new error overrides it.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    ovf_d   = ovf_q & ~bus.clr_err;
    unf_d   = unf_q & ~bus.clr_err;
    if (bus.en) begin
      if (bus.call) begin
        if (full_s) begin
          ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (SPW'(i) == sp_q) begin
              stack_d[i] = pc_inc_s;
            end else begin
              stack_d[i] = stack_q[i];
            end
          end
          sp_d = sp_q + SPW'(1);
          pc_d = bus.addr;
        end
      end else if (bus.ret) begin
        if (empty_s) begin
          unf_d = 1'b1;
        end else begin
          pc_d = top_s;
          sp_d = sp_q - SPW'(1);
        end
      end else if (bus.jmp) begin
        pc_d = bus.addr;
      end else if (bus.inc) begin
        pc_d = pc_inc_s;
      end else begin
        pc_d = pc_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // State registers; stack contents are cleared only for determinism.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      sp_q  <= {SPW{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.sp_level  = sp_q;
  assign bus.stk_full  = full_s;
  assign bus.stk_empty = empty_s;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
